// File: rtl/vdma_wr_pkg.sv
// Shared definitions for the memory-write DMA: register offsets, FSM encoding and
// status bit positions.
package vdma_wr_pkg;

  localparam logic [3:0] REG_PTR    = 4'h0;
  localparam logic [3:0] REG_DATA   = 4'h1;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_ADDR_H = 4'hC;
  localparam logic [3:0] REG_ADDR_L = 4'hD;
  localparam logic [3:0] REG_STEP   = 4'hE;
  localparam logic [3:0] REG_LEN    = 4'hF;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHold    = 3'd1,
    StSettle  = 3'd2,
    StWrite   = 3'd3,
    StAdvance = 3'd4
  } state_e;

  localparam int unsigned CTRL_DONE = 7;
  localparam int unsigned CTRL_IEN  = 6;
  localparam int unsigned CTRL_BUSY = 5;
  localparam int unsigned CTRL_FILL = 1;

endpackage

// File: rtl/vdma_wr_buf.sv
// Byte buffer for vdma_wr: CPU read/write port plus an asynchronous read-only DMA port.
module vdma_wr_buf #(
  parameter int unsigned Depth = 64,
  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic          clk,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  input  logic [AW-1:0] dma_addr,
  output logic [7:0]    dma_rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_addr] <= cpu_wdata;
  end

  assign cpu_rdata = mem[cpu_addr];
  assign dma_rdata = mem[dma_addr];

endmodule

// File: rtl/vdma_wr.sv
// Memory-write DMA: CPU fills a byte buffer, then the block steals the bus via hold and
// writes the bytes out. Define VDMA_WR_FILL_EN to enable the FILL (memset) mode.
module vdma_wr
  import vdma_wr_pkg::*;
#(
  parameter int unsigned BUF_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        rw,
  input  logic        cs,
  output logic        irq,
  output logic        hold,
  output logic [15:0] WADDR,
  output logic [7:0]  WDATA,
  output logic        WE
);

  localparam int unsigned PtrW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

  state_e          state_q, state_d;
  logic            hold_q, hold_d;
  logic [PtrW-1:0] ptr_q, rd_q;
  logic [15:0]     addr_q;
  logic [7:0]      step_q, len_q, cnt_q, do_q;
  logic            ien_q, done_q, fill;
  logic            advance, set_done;

  logic            cpu_wr, cpu_rd, len_wr;
  logic [7:0]      cnt_inc, rdata, buf_cpu_rdata;

  assign cpu_wr  = cs & ~rw;
  assign cpu_rd  = cs & rw;
  assign len_wr  = cpu_wr && (AD == REG_LEN);
  assign cnt_inc = cnt_q + 8'd1;

`ifdef VDMA_WR_FILL_EN
  logic fill_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= 1'b0;
    end else if (cpu_wr && (AD == REG_CTRL)) begin
      fill_q <= DI[CTRL_FILL];
    end
  end
  assign fill = fill_q;
`else
  assign fill = 1'b0;
`endif

  vdma_wr_buf #(
    .Depth (BUF_SIZE)
  ) u_buf (
    .clk       (clk),
    .cpu_we    (cpu_wr && (AD == REG_DATA)),
    .cpu_addr  (ptr_q),
    .cpu_wdata (DI),
    .cpu_rdata (buf_cpu_rdata),
    .dma_addr  (fill ? '0 : rd_q),
    .dma_rdata (WDATA)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    advance  = 1'b0;
    set_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cnt_q != len_q) begin
          state_d = StHold;
          hold_d  = 1'b1;
        end
      end
      StHold:   state_d = StSettle;
      StSettle: state_d = StWrite;
      StWrite:  state_d = StAdvance;
      StAdvance: begin
        advance = 1'b1;
        // A length write landing here restarts the count; the new length decides.
        if (len_wr) begin
          if (DI == 8'd0) begin
            state_d = StIdle;
            hold_d  = 1'b0;
          end else begin
            state_d = StWrite;
          end
        end else if (cnt_inc == len_q) begin
          state_d  = StIdle;
          hold_d   = 1'b0;
          set_done = 1'b1;
        end else if (len_q == 8'd0) begin
          state_d = StIdle;
          hold_d  = 1'b0;
        end else begin
          state_d = StWrite;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    rdata = 8'h00;
    case (AD)
      REG_PTR:    rdata[PtrW-1:0] = ptr_q;
      REG_DATA:   rdata = buf_cpu_rdata;
      REG_CTRL: begin
        rdata[CTRL_DONE] = done_q;
        rdata[CTRL_IEN]  = ien_q;
        rdata[CTRL_BUSY] = (state_q != StIdle);
        rdata[CTRL_FILL] = fill;
      end
      REG_ADDR_H: rdata = addr_q[15:8];
      REG_ADDR_L: rdata = addr_q[7:0];
      REG_STEP:   rdata = step_q;
      REG_LEN:    rdata = len_q;
      default:    rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= 1'b0;
      ptr_q   <= '0;
      rd_q    <= '0;
      addr_q  <= 16'h0000;
      step_q  <= 8'd1;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      do_q    <= 8'h00;
      ien_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;

      if (cpu_rd) do_q <= rdata;
      if (cs && (AD == REG_DATA)) ptr_q <= ptr_q + PtrW'(1);

      if (set_done) begin
        done_q <= 1'b1;
      end else if (cpu_rd && (AD == REG_CTRL)) begin
        done_q <= 1'b0;
      end

      if (len_wr) begin
        cnt_q <= 8'd0;
        rd_q  <= '0;
      end else if (advance) begin
        cnt_q <= cnt_inc;
        rd_q  <= rd_q + PtrW'(1);
      end

      if (advance) addr_q <= addr_q + {8'h00, step_q};

      // CPU register writes take priority over a concurrent address advance.
      if (cpu_wr) begin
        case (AD)
          REG_PTR:    ptr_q         <= DI[PtrW-1:0];
          REG_CTRL:   ien_q         <= DI[CTRL_IEN];
          REG_ADDR_H: addr_q[15:8]  <= DI;
          REG_ADDR_L: addr_q[7:0]   <= DI;
          REG_STEP:   step_q        <= DI;
          REG_LEN:    len_q         <= DI;
          default: ;
        endcase
      end
    end
  end

  assign DO    = do_q;
  assign hold  = hold_q;
  assign WE    = (state_q == StWrite);
  assign WADDR = addr_q;
  assign irq   = done_q & ien_q;

endmodule
